reg_bank_16x16: RTL and testbench

Sixteen-entry, 16-bit-wide register bank with an integrated busy scoreboard for the pipelined datapath. Holds architectural register state, presents all sixteen words as one flattened 256-bit bus to the downstream 16:1 read-select muxes, and tracks in-flight destination registers so issue logic can stall on read-after-write hazards. Single write port at writeback, single reservation port at issue.

---
 rtl/reg_bank_pkg.sv | 35 +++
 rtl/reg_scoreboard.sv | 114 +++++++++++
 rtl/reg_bank_16x16.sv | 89 ++++++++
 tb/tb_reg_bank_16x16.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared constants for the 16x16 register bank and its busy scoreboard.
//   WORD_W     : register width in bits
//   NUM_REGS   : number of architectural registers
//   ADDR_W     : register index width
//   SB_IDLE    : scoreboard state, no write in flight
//   SB_PENDING : scoreboard state, a producer owns the register
// The scoreboard state is one bit per register, so the state vector and
// the BUSY vector share the same encoding (PENDING == busy).
// -----------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int WORD_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  localparam logic [0:0] SB_IDLE    = 1'b0;
  localparam logic [0:0] SB_PENDING = 1'b1;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  typedef logic [ADDR_W-1:0]   reg_addr_t;

  // One-hot select of a register index, qualified by its strobe.
  function automatic reg_mask_t addr_sel(input logic en, input reg_addr_t addr);
    reg_mask_t sel;
    sel = '0;
    if (en) begin
      sel[addr] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy tracking for read-after-write hazard detection.
// Each register has a one-bit IDLE/PENDING state machine:
//   IDLE    -> PENDING on a reservation
//   PENDING -> IDLE    on a writeback (unless a reservation for the same
//                      register lands in the same cycle: the new producer
//                      takes ownership and the register stays PENDING)
// Strobe semantics: i_wr_en / i_rsv_en are single-cycle, always-accepted
// strobes; there is no back-pressure. Each strobe counts once per rising
// edge on which it is high.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_wr_en, i_wr_addr   : writeback strobe and destination
//   i_rsv_en, i_rsv_addr : issue reservation strobe and destination
//   i_chk_a, i_chk_b     : source operand indices
//   i_chk_en             : bit0 qualifies i_chk_a, bit1 qualifies i_chk_b
//   o_busy               : registered state vector (bit set = PENDING)
//   o_stall              : combinational hazard on a qualified source
//   o_wr_err             : sticky, writeback to an IDLE register
//   o_rsv_err            : sticky, reservation of a PENDING register
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_bank_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic                i_rsv_en,
  input  logic [ADDR_W-1:0]   i_rsv_addr,
  input  logic [ADDR_W-1:0]   i_chk_a,
  input  logic [ADDR_W-1:0]   i_chk_b,
  input  logic [1:0]          i_chk_en,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_stall,
  output logic                o_wr_err,
  output logic                o_rsv_err
);

  logic [NUM_REGS-1:0] r_state;
  logic [NUM_REGS-1:0] w_state_next;
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [NUM_REGS-1:0] w_rsv_sel;
  logic [NUM_REGS-1:0] w_idle;
  logic                w_wr_err_set;
  logic                w_rsv_err_set;
  logic                w_hazard_a;
  logic                w_hazard_b;
  logic                r_wr_err;
  logic                r_rsv_err;

  assign w_wr_sel  = addr_sel(i_wr_en, i_wr_addr);
  assign w_rsv_sel = addr_sel(i_rsv_en, i_rsv_addr);

  // Per-register next-state logic.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb_fsm
    logic w_nxt;

    always_comb begin
      w_nxt = r_state[gi];
      case (r_state[gi])
        SB_IDLE: begin
          if (w_rsv_sel[gi]) begin
            w_nxt = SB_PENDING;
          end
        end
        SB_PENDING: begin
          // A same-cycle reservation hands the register to the new producer.
          if (w_wr_sel[gi] && !w_rsv_sel[gi]) begin
            w_nxt = SB_IDLE;
          end
        end
        default: w_nxt = SB_IDLE;
      endcase
    end

    assign w_state_next[gi] = w_nxt;
    assign w_idle[gi]       = (r_state[gi] == SB_IDLE);
  end

  // Writeback with no outstanding reservation on its destination.
  assign w_wr_err_set  = |(w_wr_sel & w_idle);
  // Re-reserving a PENDING register is only legal when that register's
  // current producer retires in the same cycle.
  assign w_rsv_err_set = |(w_rsv_sel & ~w_idle & ~w_wr_sel);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= '0;
      r_wr_err  <= 1'b0;
      r_rsv_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_err_set) begin
        r_wr_err <= 1'b1;
      end
      if (w_rsv_err_set) begin
        r_rsv_err <= 1'b1;
      end
    end
  end

  // Hazard check uses only the registered state; no forwarding of
  // same-cycle strobes.
  assign w_hazard_a = i_chk_en[0] & ~w_idle[i_chk_a];
  assign w_hazard_b = i_chk_en[1] & ~w_idle[i_chk_b];

  assign o_busy    = r_state;
  assign o_stall   = w_hazard_a | w_hazard_b;
  assign o_wr_err  = r_wr_err;
  assign o_rsv_err = r_rsv_err;

endmodule

// File: rtl/reg_bank_16x16.sv
// -----------------------------------------------------------------------------
// reg_bank_16x16
// Sixteen 16-bit architectural registers with a busy scoreboard. All
// registers are presented on one flattened bus for the downstream read
// muxes; register i occupies REGS[16*i+15:16*i].
// Optional build macro: REG0_ZERO_EN
//   defined   : register 0 reads as zero; writes and reservations to
//               address 0 are dropped before reaching storage or the
//               scoreboard, so BUSY[0] stays 0 and no error is flagged.
//   undefined : register 0 is an ordinary register.
// Ports:
//   CLK, RST_N        : rising-edge clock, asynchronous active-low reset
//   WR_EN, WR_ADDR,
//   WR_DATA           : writeback port (data visible after the edge)
//   RSV_EN, RSV_ADDR  : issue-stage reservation port
//   CHK_A, CHK_B,
//   CHK_EN            : source operand hazard query
//   REGS              : flattened register contents (registered)
//   BUSY              : per-register pending-write flags (registered)
//   STALL             : combinational hazard on a qualified source
//   WR_ERR, RSV_ERR   : sticky protocol error flags, cleared by reset
// -----------------------------------------------------------------------------
module reg_bank_16x16
  import reg_bank_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       WR_EN,
  input  logic [ADDR_W-1:0]          WR_ADDR,
  input  logic [WORD_W-1:0]          WR_DATA,
  input  logic                       RSV_EN,
  input  logic [ADDR_W-1:0]          RSV_ADDR,
  input  logic [ADDR_W-1:0]          CHK_A,
  input  logic [ADDR_W-1:0]          CHK_B,
  input  logic [1:0]                 CHK_EN,
  output logic [NUM_REGS*WORD_W-1:0] REGS,
  output logic [NUM_REGS-1:0]        BUSY,
  output logic                       STALL,
  output logic                       WR_ERR,
  output logic                       RSV_ERR
);

  word_t r_mem [NUM_REGS];
  logic  w_wr_en;
  logic  w_rsv_en;

`ifdef REG0_ZERO_EN
  // Address-0 traffic is discarded here so register 0 keeps its reset
  // value of zero and the scoreboard never sees it.
  assign w_wr_en  = WR_EN  && (WR_ADDR  != '0);
  assign w_rsv_en = RSV_EN && (RSV_ADDR != '0);
`else
  assign w_wr_en  = WR_EN;
  assign w_rsv_en = RSV_EN;
`endif

  // Data storage. No bypass: a write lands on the edge and is visible on
  // REGS afterwards.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[WR_ADDR] <= WR_DATA;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flatten
    assign REGS[gi*WORD_W +: WORD_W] = r_mem[gi];
  end

  reg_scoreboard u_scoreboard (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (WR_ADDR),
    .i_rsv_en   (w_rsv_en),
    .i_rsv_addr (RSV_ADDR),
    .i_chk_a    (CHK_A),
    .i_chk_b    (CHK_B),
    .i_chk_en   (CHK_EN),
    .o_busy     (BUSY),
    .o_stall    (STALL),
    .o_wr_err   (WR_ERR),
    .o_rsv_err  (RSV_ERR)
  );

endmodule

// File: tb/tb_reg_bank_16x16.sv
module tb_reg_bank_16x16;

`ifdef REG0_ZERO_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         rsv_en;
  logic [3:0]   rsv_addr;
  logic [3:0]   chk_a;
  logic [3:0]   chk_b;
  logic [1:0]   chk_en;
  logic [255:0] regs;
  logic [15:0]  busy;
  logic         stall;
  logic         wr_err;
  logic         rsv_err;

  always #5 clk = ~clk;

  reg_bank_16x16 dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .WR_EN    (wr_en),
    .WR_ADDR  (wr_addr),
    .WR_DATA  (wr_data),
    .RSV_EN   (rsv_en),
    .RSV_ADDR (rsv_addr),
    .CHK_A    (chk_a),
    .CHK_B    (chk_b),
    .CHK_EN   (chk_en),
    .REGS     (regs),
    .BUSY     (busy),
    .STALL    (stall),
    .WR_ERR   (wr_err),
    .RSV_ERR  (rsv_err)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_wr_err;
  logic        m_rsv_err;
  logic [15:0] m_old_busy;
  logic        m_wr_ok;
  logic        m_rsv_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_busy    = '0;
      m_wr_err  = 1'b0;
      m_rsv_err = 1'b0;
    end else begin
      m_old_busy = m_busy;
      m_wr_ok    = wr_en  && !(ZERO && wr_addr == 4'd0);
      m_rsv_ok   = rsv_en && !(ZERO && rsv_addr == 4'd0);
      if (m_wr_ok) begin
        if (!m_old_busy[wr_addr]) m_wr_err = 1'b1;
        m_regs[wr_addr]  = wr_data;
        m_busy[wr_addr]  = 1'b0;
      end
      if (m_rsv_ok) begin
        if (m_old_busy[rsv_addr] && !(m_wr_ok && wr_addr == rsv_addr)) m_rsv_err = 1'b1;
        m_busy[rsv_addr] = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [255:0] e;
    logic         s;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < 16; i++) e[16*i +: 16] = m_regs[i];
        s = (chk_en[0] && m_busy[chk_a]) || (chk_en[1] && m_busy[chk_b]);
        check("cyc_regs",    regs,    e);
        check("cyc_busy",    busy,    m_busy);
        check("cyc_stall",   stall,   s);
        check("cyc_wr_err",  wr_err,  m_wr_err);
        check("cyc_rsv_err", rsv_err, m_rsv_err);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic [3:0] ca, input logic [3:0] cb, input logic [1:0] ce);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    chk_a = ca; chk_b = cb; chk_en = ce;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic reset_pulse(input bit do_check);
    #1;
    rst_n = 1'b0;
    #1;
    if (do_check) begin
      check("rst_regs",    regs,    256'd0);
      check("rst_busy",    busy,    256'd0);
      check("rst_wr_err",  wr_err,  256'd0);
      check("rst_rsv_err", rsv_err, 256'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] exp_v;

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    chk_a = 0; chk_b = 0; chk_en = 0;
    fork compare_loop(); join_none
    repeat (2) @(posedge clk);
    #2;
    check("reset_regs",  regs,  256'd0);
    check("reset_busy",  busy,  256'd0);
    check("reset_stall", stall, 256'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Unreserved write to register 5.
    drive(1'b1, 4'd5, 16'hA5A5, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
    exp_v = '0;
    exp_v[95:80] = 16'hA5A5;
    check("wr5_regs",   regs,   exp_v);
    check("wr5_wr_err", wr_err, 256'd1);
    idle();

    // Reserve 3, check stall, then retire it.
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 4'd3, 4'd0, 2'b01);
    check("rsv3_stall", stall, 256'd1);
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd0, 2'b01);
    check("wr3_busy3", busy[3], 256'd0);
    check("wr3_stall", stall,   256'd0);
    check("wr3_data",  regs[63:48], 256'h1234);
    idle();

    // Reserve 7, then re-reserve and write 7 together: new producer owns it.
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 4'd0, 4'd0, 2'b00);
    drive(1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd7, 4'd0, 4'd7, 2'b10);
    check("r7_busy7",   busy[7],       256'd1);
    check("r7_data",    regs[127:112], 256'hBEEF);
    check("r7_rsv_err", rsv_err,       256'd0);
    check("r7_stall_b", stall,         256'd1);
    drive(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);

    // Double reservation of 9.
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 4'd0, 4'd0, 2'b00);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 4'd0, 4'd0, 2'b00);
    check("r9_rsv_err", rsv_err, 256'd1);
    check("r9_busy9",   busy[9], 256'd1);
    drive(1'b1, 4'd9, 16'h0909, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd2, 4'd0, 4'd0, 2'b00);
    drive(1'b1, 4'd2, 16'h0202, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
    check("r9_sticky", rsv_err, 256'd1);
    reset_pulse(1'b1);

    // Fill all registers, leave some reserved, then reset between edges.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 16'(16'h1111 * i), 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
    end
    check("fill_regs", regs, {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA,
                              16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444,
                              16'h3333, 16'h2222, 16'h1111, 16'h0000});
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd2, 4'd0, 4'd0, 2'b00);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 4'd0, 4'd0, 2'b00);
    check("fill_busy", busy, 256'h0014);
    reset_pulse(1'b1);

    // Address-0 traffic.
    drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0, 2'b00);
    idle();
`ifdef REG0_ZERO_EN
    check("a0_data",    regs[15:0], 256'h0000);
    check("a0_busy0",   busy[0],    256'd0);
    check("a0_wr_err",  wr_err,     256'd0);
    check("a0_rsv_err", rsv_err,    256'd0);
`else
    check("a0_data",    regs[15:0], 256'hFFFF);
    check("a0_busy0",   busy[0],    256'd1);
    check("a0_wr_err",  wr_err,     256'd1);
    check("a0_rsv_err", rsv_err,    256'd0);
`endif
    reset_pulse(1'b0);

    // Randomised traffic checked every cycle against the model.
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 499) begin
        reset_pulse(1'b1);
      end else begin
        drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)));
      end
    end
    idle();
    @(negedge clk);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
